vrom_scan_ctrl: RTL
===================

Name: vrom_scan_ctrl

Overview:
- Sequencer for the library-vector ROM (VROM).
- On a start command, streams a contiguous index range [base_idx, base_idx+count-1] out of the ROM to a downstream valid/ready consumer (the similarity/compare stage), tagging each vector with its index and marking the last beat.
- Sole master of the ROM read port. Full throughput: one vector per cycle when the consumer is always ready.

Parameters:
- ROM_DEPTH, 15486, number of library vectors in the ROM.
- DATA_WIDTH, 1100, vector width in bits.
- ADDR_WIDTH, $clog2(ROM_DEPTH), index/address width.
- CNT_WIDTH, $clog2(ROM_DEPTH+1), width of the count field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle command strobe, accepted only in IDLE
- abort  in  1  cancel the scan in progress
- base_idx  in  ADDR_WIDTH  first index, sampled on an accepted start
- count  in  CNT_WIDTH  number of vectors, sampled on an accepted start
- busy  out  1  high from the cycle after an accepted start until done/abort
- done  out  1  one-cycle pulse after the last beat is consumed
- range_err  out  1  sticky: requested range exceeded ROM_DEPTH; cleared on the next accepted start
- rom_arvalid  out  1  ROM read request
- rom_araddr  out  ADDR_WIDTH  ROM read address
- rom_rready  out  1  driven equal to rom_arvalid
- rom_rvalid  in  1  ROM valid; informational only, see Behaviour
- rom_rdata  in  DATA_WIDTH  ROM read data
- out_valid  out  1  vector beat valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_WIDTH  vector, passed through from rom_rdata
- out_index  out  ADDR_WIDTH  index of out_data
- out_last  out  1  final beat of the scan

Behaviour:
- Clocking and reset: single clock, synchronous active-low reset. All control flops are reset; out_data is not reset.
- Reset values: state=IDLE; busy, done, range_err, rom_arvalid, rom_rready, out_valid, out_last = 0; rom_araddr, out_index = 0.
- ROM contract: read accepted when rom_arvalid && rom_rready; data appears on rom_rdata one cycle later and holds until the next accepted read. The ROM's rvalid stays high after the first read, so it is NOT a per-beat strobe. Beat tracking uses an internal pend flag.
- pend: set the cycle after a read is issued; cleared when out_valid && out_ready with no new read issued in the same cycle.
- Outputs: out_valid = pend; out_data = rom_rdata (combinational); out_index and out_last are registered alongside each issued read.
- Issue rule: in SCAN, issue when (!pend || out_ready) and reads remain. Issuing while pend && out_ready gives back-to-back beats.
- Backpressure: when out_ready is low with pend set, no read is issued and out_data stays stable.
- State IDLE: start -> SCAN. Latch base/count and set the end index.
  - If base_idx+count > ROM_DEPTH: set range_err and clamp the end index to ROM_DEPTH-1.
  - If count==0 or base_idx >= ROM_DEPTH: go directly to DONE with no reads; range_err is set if base_idx >= ROM_DEPTH.
- State SCAN: issue reads base..end in order. The last issue moves the FSM to DRAIN.
- State DRAIN: wait for the last beat (out_last) to be consumed -> DONE.
- State DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while busy: ignored; it does not alter the range.
- abort in SCAN/DRAIN: next cycle state=IDLE, pend=0, out_valid=0, no done pulse; range_err is kept. abort in IDLE/DONE: ignored.
- start and abort in the same IDLE cycle: start wins.
- Arithmetic: the end-index computation is done at CNT_WIDTH+1 bits so it cannot overflow.

Optional Feature:
- Macro: VROM_SCAN_PERF_EN.
- Defined: adds output stall_cnt [31:0], a saturating counter of cycles with out_valid && !out_ready. Cleared on an accepted start; holds after done or abort.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Package vrom_pkg: ROM_DEPTH, DATA_WIDTH and ADDR_WIDTH defaults; scan_state_e enum {IDLE, SCAN, DRAIN, DONE}. The VROM and this block share the package.
- One sub-module, vrom_scan_addr_gen: loadable address counter with end compare, producing rom_araddr and the last flag. The FSM and pend logic stay in the top.

Test Plan:
- base=0, count=4, out_ready=1 -> rom_araddr 0,1,2,3 on consecutive cycles; out_index 0..3 back-to-back; out_last only on index 3; done pulses 1 cycle after that beat; busy spans exactly the scan.
- base=10, count=3, out_ready toggled 1,0,0,1,... -> no address issued while stalled; out_data and out_index stable during stall; exactly 3 beats 10,11,12 delivered; no duplicates.
- base=15484, count=5 -> range_err=1; beats 15484 and 15485 only; out_last on 15485; done pulses.
- count=0 -> no rom_arvalid; done 1 cycle after busy; range_err=0.
- abort after 2 of 8 beats -> out_valid low next cycle; no done; a following start base=0 count=1 delivers index 0 correctly.
- With VROM_SCAN_PERF_EN: 5 forced stall cycles during a scan -> stall_cnt=5 at done.

Source files
------------

// File: rtl/vrom_pkg.sv
// vrom_pkg: shared constants and scan FSM encoding for the library-vector ROM and its scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vrom_pkg;

    // Default geometry of the library-vector ROM.
    localparam int VROM_DEPTH      = 15486;
    localparam int VROM_DATA_WIDTH = 1100;
    localparam int VROM_ADDR_WIDTH = $clog2(VROM_DEPTH);

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/vrom_scan_addr_gen.sv
// vrom_scan_addr_gen: loadable ROM address counter with end-of-range compare.
// Latency: load/advance take effect on the next clock; last is combinational from the current address.
// Backpressure: advances only when the caller asserts adv; holds otherwise.
module vrom_scan_addr_gen
    import vrom_pkg::*;
#(
    parameter int ADDR_WIDTH = VROM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [ADDR_WIDTH-1:0] load_end,
    input  logic                  adv,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] end_q,  end_d;

    // The address parks on the end index once reached; the FSM stops issuing there.
    assign addr = addr_q;
    assign last = (addr_q == end_q);

    // Next address: a load overrides any advance.
    always_comb begin
        addr_d = addr_q;
        end_d  = end_q;
        if (load) begin
            addr_d = load_addr;
            end_d  = load_end;
        end else if (adv && !last) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
    end

    // Address and end registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            end_q  <= '0;
        end else begin
            addr_q <= addr_d;
            end_q  <= end_d;
        end
    end

endmodule

// File: rtl/vrom_scan_ctrl.sv
// vrom_scan_ctrl: streams VROM vectors [base_idx, base_idx+count-1] to a valid/ready consumer with index and last tags.
// Latency: first ROM read the cycle after an accepted start, first beat one cycle later; one beat per cycle at full ready.
// Backpressure: out_ready low with a beat pending stops read issue; out_data/out_index hold. Macro VROM_SCAN_PERF_EN adds stall_cnt.
module vrom_scan_ctrl
    import vrom_pkg::*;
#(
    parameter int ROM_DEPTH  = VROM_DEPTH,
    parameter int DATA_WIDTH = VROM_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(ROM_DEPTH),
    parameter int CNT_WIDTH  = $clog2(ROM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_idx,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err,
    output logic                  rom_arvalid,
    output logic [ADDR_WIDTH-1:0] rom_araddr,
    output logic                  rom_rready,
    input  logic                  rom_rvalid,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
`ifdef VROM_SCAN_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    // Range arithmetic is one bit wider than count so base+count never wraps.
    localparam logic [CNT_WIDTH:0]    DEPTH_EXT = (CNT_WIDTH + 1)'(ROM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(ROM_DEPTH - 1);

    scan_state_e           state_q, state_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  range_err_q, range_err_d;

    logic                  accept;
    logic                  issue;
    logic                  consume;
    logic                  abort_hit;

    logic [CNT_WIDTH:0]    base_ext;
    logic [CNT_WIDTH:0]    cnt_ext;
    logic [CNT_WIDTH:0]    range_sum;
    logic [CNT_WIDTH:0]    range_sum_m1;
    logic                  base_oob;
    logic                  range_empty;
    logic                  range_over;
    logic [ADDR_WIDTH-1:0] end_idx;

    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;

    // The ROM's rvalid stays high after the first read, so it carries no per-beat information.
    logic                  unused_rom_rvalid;
    assign unused_rom_rvalid = rom_rvalid;

    // Requested range decode: out-of-range base, empty request, overrun clamp.
    always_comb begin
        base_ext     = (CNT_WIDTH + 1)'(base_idx);
        cnt_ext      = (CNT_WIDTH + 1)'(count);
        range_sum    = base_ext + cnt_ext;
        range_sum_m1 = range_sum - (CNT_WIDTH + 1)'(1);
        base_oob     = (base_ext >= DEPTH_EXT);
        range_empty  = (count == '0);
        range_over   = (range_sum > DEPTH_EXT);
        end_idx      = range_over ? LAST_IDX : ADDR_WIDTH'(range_sum_m1);
    end

    // Address counter owning rom_araddr and the end-of-range flag.
    vrom_scan_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_addr (base_idx),
        .load_end  (end_idx),
        .adv       (issue),
        .addr      (gen_addr),
        .last      (gen_last)
    );

    assign consume   = pend_q && out_ready;
    assign abort_hit = abort && ((state_q == SCAN) || (state_q == DRAIN));

    // Scan FSM: start acceptance, read issue and completion.
    always_comb begin
        state_d     = state_q;
        range_err_d = range_err_q;
        accept      = 1'b0;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                // start beats a simultaneous abort because abort has no meaning here.
                if (start) begin
                    accept      = 1'b1;
                    range_err_d = base_oob || range_over;
                    state_d     = (range_empty || base_oob) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pend_q || out_ready) begin
                    // Slot is free now or frees at this edge: keep the pipe full.
                    issue = 1'b1;
                    if (gen_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (consume && out_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat tracking: pend marks ROM data belonging to an issued read not yet consumed.
    always_comb begin
        pend_d      = pend_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        if (abort_hit) begin
            pend_d     = 1'b0;
            out_last_d = 1'b0;
        end else if (issue) begin
            pend_d      = 1'b1;
            out_index_d = gen_addr;
            out_last_d  = gen_last;
        end else if (consume) begin
            pend_d     = 1'b0;
            out_last_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            range_err_q <= range_err_d;
        end
    end

    assign busy        = (state_q == SCAN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign range_err   = range_err_q;
    assign rom_arvalid = issue;
    assign rom_rready  = issue;
    assign rom_araddr  = gen_addr;
    assign out_valid   = pend_q;
    assign out_data    = rom_rdata;
    assign out_index   = out_index_q;
    assign out_last    = out_last_q;

`ifdef VROM_SCAN_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles a beat waits on the consumer; restarts with each accepted start.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            stall_cnt_d = '0;
        end else if (pend_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
